mgnt_bus_arbiter: RTL and testbench

- Shares the single system-management request bus (cmd/tx/rx channels toward the port, BE-switch and TTE-switch register targets) between NUM_REQ masters.
- Typical masters: the SPI register hub (requester 0) and an autonomous status/statistics poller (requester 1).
- Grants round-robin and holds the grant for one complete transaction.
- Steers tx bytes from, and rx bytes to, the granted master; aborts with an error if a target never acks.

---
 rtl/mgnt_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/mgnt_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mgnt_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgnt_pkg.sv
// Shared definitions for the management bus: target selects, FSM encoding, byte width.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mgnt_pkg;

    localparam int MGNT_REG_WIDTH = 8;

    // One-hot target selects on the management request bus
    localparam logic [MGNT_REG_WIDTH-1:0] PORT0     = 8'h01;
    localparam logic [MGNT_REG_WIDTH-1:0] PORT1     = 8'h02;
    localparam logic [MGNT_REG_WIDTH-1:0] PORT2     = 8'h04;
    localparam logic [MGNT_REG_WIDTH-1:0] PORT3     = 8'h08;
    localparam logic [MGNT_REG_WIDTH-1:0] BE_SW     = 8'h10;
    localparam logic [MGNT_REG_WIDTH-1:0] BE_SW_FT  = 8'h20;
    localparam logic [MGNT_REG_WIDTH-1:0] BE_SW_FTM = 8'h40;
    localparam logic [MGNT_REG_WIDTH-1:0] TTE_SW    = 8'h80;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_BUSY    = 4'b0010,
        ST_DONE    = 4'b0100,
        ST_RELEASE = 4'b1000
    } state_t;

    // A select is usable only when it names exactly one known target
    function automatic logic legal_target(input logic [MGNT_REG_WIDTH-1:0] sel);
        case (sel)
            PORT0, PORT1, PORT2, PORT3,
            BE_SW, BE_SW_FT, BE_SW_FTM, TTE_SW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester above the last-served index, wrapping around.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic [N-1:0]  gnt
);

    // Walk from the farthest slot to the nearest so the nearest requester overwrites
    always_comb begin
        gnt = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (i == (int'(last) + k) % N)) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mgnt_bus_arbiter.sv
// Shares the management request bus between NUM_REQ masters, one whole transaction per grant.
// Latency: request to s_req_valid 1 cycle; at least 3 idle-bus cycles between transactions.
// Backpressure: masters hold requests until m_req_ack; a silent target is aborted after TIMEOUT cycles.
module mgnt_bus_arbiter
    import mgnt_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ*8-1:0]        m_req_valid,
    input  logic [NUM_REQ-1:0]          m_req_wr,
    input  logic [NUM_REQ*8-1:0]        m_req_addr,
    input  logic [NUM_REQ*8-1:0]        m_req_data,
    input  logic [NUM_REQ-1:0]          m_req_data_valid,
    output logic [NUM_REQ-1:0]          m_req_ack,
    output logic [NUM_REQ-1:0]          m_req_err,
    output logic [MGNT_REG_WIDTH-1:0]   m_resp_data,
    output logic [NUM_REQ-1:0]          m_resp_data_valid,
    output logic [MGNT_REG_WIDTH-1:0]   s_req_valid,
    output logic                        s_req_wr,
    output logic [MGNT_REG_WIDTH-1:0]   s_req_addr,
    input  logic                        s_req_ack,
    output logic [MGNT_REG_WIDTH-1:0]   s_req_data,
    output logic                        s_req_data_valid,
    input  logic [MGNT_REG_WIDTH-1:0]   s_resp_data,
    input  logic                        s_resp_data_valid,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam int              PW      = $clog2(NUM_REQ);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t                    state, state_nxt;
    logic [NUM_REQ-1:0]        req, win_gnt;
    logic [PW-1:0]             ptr, srv_idx;
    logic [MGNT_REG_WIDTH-1:0] win_sel, win_addr, tx_byte;
    logic                      win_wr, tx_vld, win_legal;
    logic [TO_W-1:0]           to_cnt;
    logic                      err_flag;

    // Any nonzero target select counts as a pending request
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = |m_req_valid[8*i +: 8];
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req  (req),
        .last (ptr),
        .gnt  (win_gnt)
    );

    // Pick out the arbitration winner's request fields
    always_comb begin
        win_sel  = '0;
        win_wr   = 1'b0;
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_sel  = m_req_valid[8*i +: 8];
                win_wr   = m_req_wr[i];
                win_addr = m_req_addr[8*i +: 8];
            end
        end
    end

    assign win_legal = legal_target(win_sel);

    // Steer the granted master's tx byte and remember its index for the pointer
    always_comb begin
        tx_byte = '0;
        tx_vld  = 1'b0;
        srv_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                tx_byte = m_req_data[8*i +: 8];
                tx_vld  = m_req_data_valid[i];
                srv_idx = PW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the state-qualified outputs; data paths are open only in BUSY
    always_comb begin
        state_nxt         = state;
        busy              = 1'b0;
        m_req_ack         = '0;
        m_req_err         = '0;
        s_req_data        = '0;
        s_req_data_valid  = 1'b0;
        m_resp_data       = '0;
        m_resp_data_valid = '0;
        case (state)
            ST_IDLE: begin
                if (|req) state_nxt = win_legal ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                busy              = 1'b1;
                s_req_data        = tx_byte;
                s_req_data_valid  = tx_vld;
                m_resp_data       = s_resp_data;
                m_resp_data_valid = grant & {NUM_REQ{s_resp_data_valid}};
                if (s_req_ack || (to_cnt == TO_LAST)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                m_req_ack = grant;
                m_req_err = err_flag ? grant : '0;
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant/request latches, timeout counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            ptr         <= PW'(NUM_REQ - 1);
            to_cnt      <= '0;
            err_flag    <= 1'b0;
            s_req_valid <= '0;
            s_req_wr    <= 1'b0;
            s_req_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant  <= win_gnt;
                        to_cnt <= '0;
                        if (win_legal) begin
                            s_req_valid <= win_sel;
                            s_req_wr    <= win_wr;
                            s_req_addr  <= win_addr;
                            err_flag    <= 1'b0;
                        end else begin
                            // Bad select never reaches the targets; report it straight away
                            err_flag <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (s_req_ack) begin
                        // Ack beats a coinciding timeout
                        err_flag    <= 1'b0;
                        s_req_valid <= '0;
                        s_req_wr    <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        err_flag    <= 1'b1;
                        s_req_valid <= '0;
                        s_req_wr    <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_RELEASE: begin
                    grant <= '0;
                    ptr   <= srv_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mgnt_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_mgnt_bus_arbiter;

    localparam int N   = 2;
    localparam int TMO = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*8-1:0]   m_req_valid, m_req_addr, m_req_data;
    logic [N-1:0]     m_req_wr, m_req_data_valid;
    logic [N-1:0]     m_req_ack, m_req_err, m_resp_data_valid, grant;
    logic [7:0]       m_resp_data, s_req_valid, s_req_addr, s_req_data, s_resp_data;
    logic             s_req_wr, s_req_ack, s_req_data_valid, s_resp_data_valid, busy;

    always #5 clk = ~clk;

    mgnt_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .m_req_valid       (m_req_valid),
        .m_req_wr          (m_req_wr),
        .m_req_addr        (m_req_addr),
        .m_req_data        (m_req_data),
        .m_req_data_valid  (m_req_data_valid),
        .m_req_ack         (m_req_ack),
        .m_req_err         (m_req_err),
        .m_resp_data       (m_resp_data),
        .m_resp_data_valid (m_resp_data_valid),
        .s_req_valid       (s_req_valid),
        .s_req_wr          (s_req_wr),
        .s_req_addr        (s_req_addr),
        .s_req_ack         (s_req_ack),
        .s_req_data        (s_req_data),
        .s_req_data_valid  (s_req_data_valid),
        .s_resp_data       (s_resp_data),
        .s_resp_data_valid (s_resp_data_valid),
        .grant             (grant),
        .busy              (busy)
    );

    // Per-master drive registers, packed onto the DUT buses
    logic [7:0] mv[N], ma[N], md[N];
    logic       mw[N], mdv[N];

    always_comb begin
        m_req_valid = '0; m_req_wr = '0; m_req_addr = '0; m_req_data = '0; m_req_data_valid = '0;
        for (int i = 0; i < N; i++) begin
            m_req_valid[8*i +: 8] = mv[i];
            m_req_addr[8*i +: 8]  = ma[i];
            m_req_data[8*i +: 8]  = md[i];
            m_req_wr[i]           = mw[i];
            m_req_data_valid[i]   = mdv[i];
        end
    end

    // Reference model: outstanding requests and the last master served
    logic [7:0]   rq_tgt[N], rq_addr[N];
    logic         rq_wr[N];
    logic [N-1:0] pend;
    int           last_srv;
    logic [7:0]   rx_b[4], tx_b[4];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [7:0] tgt, input logic wr, input logic [7:0] addr);
        rq_tgt[m] = tgt; rq_wr[m] = wr; rq_addr[m] = addr; pend[m] = 1'b1;
        mv[m] = tgt; mw[m] = wr; ma[m] = addr;
    endtask

    task automatic clr_req(input int m);
        mv[m] = 8'h00; mw[m] = 1'b0; ma[m] = 8'h00; pend[m] = 1'b0;
    endtask

    // Winner = pending master at the smallest forward distance past the last one served
    function automatic int model_pick(input logic [N-1:0] p, input int lst);
        int best, bd, d;
        best = -1; bd = N + 1;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                d = (i - lst - 1 + 2*N) % N;
                if (d < bd) begin bd = d; best = i; end
            end
        end
        return best;
    endfunction

    // One transaction from grant to RELEASE. mode 0: ack after data+dly; 1: never ack; 2: ack on last legal cycle.
    task automatic serve_one(input int nrx, input int ntx, input int dly, input int mode,
                             input bit keep, input bit drop, input int exp_wait);
        int           w, waited, c, ack_c, len;
        logic [N-1:0] g;
        logic [7:0]   tgt;
        w = model_pick(pend, last_srv);
        if (w < 0) return;
        g = '0; g[w] = 1'b1;
        tgt = rq_tgt[w];
        waited = 0;
        do begin tick(); waited++; end while (grant == '0 && waited < 8);
        check_eq("grant", grant, g);
        check_eq("req_to_grant_cycles", waited, exp_wait);
        if ($countones(tgt) != 1) begin
            check_eq("illegal_ack", m_req_ack, g);
            check_eq("illegal_err", m_req_err, g);
            check_eq("illegal_s_req_valid", s_req_valid, 0);
            check_eq("illegal_busy", busy, 0);
            if (!keep) clr_req(w);
            tick();
            check_eq("illegal_rel_ack", m_req_ack, 0);
            check_eq("illegal_rel_grant", grant, g);
            last_srv = w;
            return;
        end
        check_eq("s_req_valid", s_req_valid, tgt);
        check_eq("s_req_wr", s_req_wr, rq_wr[w]);
        check_eq("s_req_addr", s_req_addr, rq_addr[w]);
        check_eq("busy_start_ack", m_req_ack, 0);
        len   = (nrx > ntx) ? nrx : ntx;
        ack_c = (mode == 0) ? len + dly : ((mode == 2) ? TMO - 1 : -1);
        c = 0;
        forever begin
            s_resp_data_valid = (c < nrx);
            s_resp_data       = (c < nrx) ? rx_b[c] : 8'h00;
            for (int i = 0; i < N; i++) begin
                mdv[i] = (i == w) ? (c < ntx) : 1'b1;
                md[i]  = (i == w && c < ntx) ? tx_b[c] : 8'hA5;
            end
            if (drop && c == 0) mv[w] = 8'h00;
            s_req_ack = (c == ack_c);
            #1;
            check_eq("busy_in_busy", busy, 1);
            check_eq("s_req_valid_held", s_req_valid, tgt);
            check_eq("s_req_wr_held", s_req_wr, rq_wr[w]);
            check_eq("m_resp_data_valid", m_resp_data_valid, (c < nrx) ? g : '0);
            if (c < nrx) check_eq("m_resp_data", m_resp_data, rx_b[c]);
            check_eq("s_req_data_valid", s_req_data_valid, (c < ntx));
            if (c < ntx) check_eq("s_req_data", s_req_data, tx_b[c]);
            if (c == ack_c || c == TMO - 1) break;
            tick();
            c++;
        end
        tick();
        check_eq("done_ack", m_req_ack, g);
        check_eq("done_err", m_req_err, (c == ack_c) ? '0 : g);
        check_eq("done_s_req_valid", s_req_valid, 0);
        check_eq("done_s_req_wr", s_req_wr, 0);
        check_eq("done_busy", busy, 0);
        // Stray traffic outside BUSY must be dropped
        s_req_ack = 1'b1; s_resp_data_valid = 1'b1;
        for (int i = 0; i < N; i++) mdv[i] = 1'b1;
        #1;
        check_eq("done_rx_dropped", m_resp_data_valid, 0);
        check_eq("done_tx_dropped", s_req_data_valid, 0);
        if (!keep) clr_req(w);
        tick();
        check_eq("rel_ack", m_req_ack, 0);
        check_eq("rel_busy", busy, 1);
        check_eq("rel_grant", grant, g);
        s_req_ack = 1'b0; s_resp_data_valid = 1'b0;
        for (int i = 0; i < N; i++) mdv[i] = 1'b0;
        last_srv = w;
    endtask

    initial begin
        logic [7:0] t;
        int         mask;
        rst = 1'b1; s_req_ack = 1'b0; s_resp_data = 8'h00; s_resp_data_valid = 1'b0;
        pend = '0; last_srv = N - 1;
        for (int i = 0; i < N; i++) begin
            mv[i] = 8'h00; ma[i] = 8'h00; md[i] = 8'h00; mw[i] = 1'b0; mdv[i] = 1'b0;
            rq_tgt[i] = 8'h00; rq_addr[i] = 8'h00; rq_wr[i] = 1'b0;
        end
        tick();
        check_eq("rst_s_req_valid", s_req_valid, 0);
        check_eq("rst_s_req_wr", s_req_wr, 0);
        check_eq("rst_s_req_addr", s_req_addr, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ack", m_req_ack, 0);
        check_eq("rst_err", m_req_err, 0);
        rst = 1'b0;
        tick(); tick();

        // Basic read from m0
        rx_b[0] = 8'hDE; rx_b[1] = 8'hAD; rx_b[2] = 8'hBE; rx_b[3] = 8'hEF;
        set_req(0, 8'h02, 1'b0, 8'h10);
        serve_one(4, 0, 0, 0, 1'b0, 1'b0, 1);

        // Write from m1
        tx_b[0] = 8'h11; tx_b[1] = 8'h22; tx_b[2] = 8'h33; tx_b[3] = 8'h44;
        set_req(1, 8'h10, 1'b1, 8'h05);
        serve_one(0, 4, 1, 0, 1'b0, 1'b0, 2);

        // Contention with both masters holding requests
        set_req(0, 8'h01, 1'b0, 8'h20);
        set_req(1, 8'h08, 1'b1, 8'h21);
        for (int k = 0; k < 4; k++) serve_one(1, 1, 0, 0, 1'b1, 1'b0, 2);
        clr_req(1);

        // Timeout without ack, then ack on the final cycle
        set_req(0, 8'h80, 1'b0, 8'h30);
        serve_one(0, 0, 0, 1, 1'b0, 1'b0, 2);
        set_req(0, 8'h80, 1'b0, 8'h31);
        serve_one(0, 0, 0, 2, 1'b0, 1'b0, 2);

        // Illegal multi-hot target
        set_req(1, 8'h03, 1'b0, 8'h40);
        serve_one(0, 0, 0, 0, 1'b0, 1'b0, 2);

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            mask = $urandom_range(1, (1 << N) - 1);
            for (int m = 0; m < N; m++) begin
                if (((mask >> m) & 1) != 0) begin
                    t = 8'h01 << $urandom_range(0, 7);
                    if ($urandom_range(0, 5) == 0) t = t | {t[6:0], t[7]};
                    set_req(m, t, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                end
            end
            while (pend != '0) begin
                for (int j = 0; j < 4; j++) begin
                    rx_b[j] = 8'($urandom_range(0, 255));
                    tx_b[j] = 8'($urandom_range(0, 255));
                end
                serve_one($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 0,
                          1'b0, ($urandom_range(0, 3) == 0), 2);
            end
        end

        // Reset in the middle of a transaction with an rx byte in flight
        set_req(1, 8'h04, 1'b0, 8'h50);
        tick(); tick();
        check_eq("mid_rst_pre_grant", grant, 2'b10);
        s_resp_data = 8'h5A; s_resp_data_valid = 1'b1;
        #1;
        check_eq("mid_rst_pre_rx_valid", m_resp_data_valid, 2'b10);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_s_req_valid", s_req_valid, 0);
        check_eq("mid_rst_grant", grant, 0);
        check_eq("mid_rst_rx_valid", m_resp_data_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ack", m_req_ack, 0);
        check_eq("mid_rst_err", m_req_err, 0);
        tick();
        check_eq("mid_rst_hold_ack", m_req_ack, 0);
        s_resp_data_valid = 1'b0;
        set_req(0, 8'h20, 1'b1, 8'h60);
        last_srv = N - 1;
        rst = 1'b0;
        serve_one(0, 2, 0, 0, 1'b0, 1'b0, 1);
        serve_one(1, 0, 0, 0, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
